comp_line_packer: RTL and testbench

//  Downstream stage of the bubble-collapsing shifter. Takes left-aligned compressed lines
//  (lifm words plus per-word mt entries, with a valid-word count) and repacks them densely

---
 rtl/comp_line_packer_pkg.sv | 27 ++
 rtl/comp_line_packer_if.sv | 31 +++
 rtl/comp_line_packer_line_concat.sv | 32 +++
 rtl/comp_line_packer.sv | 150 +++++++++++++++
 tb/tb_comp_line_packer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/comp_line_packer_pkg.sv
// Shared definitions for the compressed-line packer: geometry, state encoding,
// and the input word-count clamp.
package comp_line_packer_pkg;

   localparam int unsigned WORD_WIDTH    = 8;
   localparam int unsigned DIST_WIDTH    = 7;
   localparam int unsigned MAX_LIFM_RSIZ = 3;
   localparam int unsigned MT_W          = DIST_WIDTH * MAX_LIFM_RSIZ;
   localparam int unsigned LINE_SIZE     = 32;
   localparam int unsigned CNT_W         = $clog2(LINE_SIZE + 1);
   localparam int unsigned RES_W         = $clog2(LINE_SIZE);
   localparam int unsigned SUM_W         = CNT_W + 1;
   // One slot carries a lifm word and its mt entry side by side: {mt, lifm}.
   localparam int unsigned SLOT_W        = WORD_WIDTH + MT_W;
   localparam int unsigned WIN_SLOTS     = 2 * LINE_SIZE - 1;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_TAIL = 1'b1
   } state_e;

   // Counts above a full line are treated as a full line.
   function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
      return (c > CNT_W'(LINE_SIZE)) ? CNT_W'(LINE_SIZE) : c;
   endfunction

endpackage

// File: rtl/comp_line_packer_if.sv
// Input and output line streams of the packer, each a valid/ready handshake.
interface comp_line_packer_if;
   import comp_line_packer_pkg::*;

   logic                          in_valid;
   logic                          in_ready;
   logic [LINE_SIZE*WORD_WIDTH-1:0] in_lifm;
   logic [LINE_SIZE*MT_W-1:0]     in_mt;
   logic [CNT_W-1:0]              in_cnt;
   logic                          in_flush;

   logic                          out_valid;
   logic                          out_ready;
   logic [LINE_SIZE*WORD_WIDTH-1:0] out_lifm;
   logic [LINE_SIZE*MT_W-1:0]     out_mt;
   logic [CNT_W-1:0]              out_cnt;
   logic                          out_last;

   // Upstream source plus downstream sink (the environment around the packer).
   modport master (
      output in_valid, in_lifm, in_mt, in_cnt, in_flush, out_ready,
      input  in_ready, out_valid, out_lifm, out_mt, out_cnt, out_last
   );

   // The packer itself.
   modport slave (
      input  in_valid, in_lifm, in_mt, in_cnt, in_flush, out_ready,
      output in_ready, out_valid, out_lifm, out_mt, out_cnt, out_last
   );

endinterface

// File: rtl/comp_line_packer_line_concat.sv
// Combinational funnel: places the first cnt_i words of in_i at slot offset
// off_i of a WIN-slot window; every other slot is zero.
module line_concat #(
   parameter int unsigned W     = 29,
   parameter int unsigned N     = 32,
   parameter int unsigned WIN   = 63,
   parameter int unsigned CNT_W = 6,
   parameter int unsigned OFF_W = 5
) (
   input  logic [N*W-1:0]   in_i,
   input  logic [CNT_W-1:0] cnt_i,
   input  logic [OFF_W-1:0] off_i,
   output logic [WIN*W-1:0] win_o
);

   logic [N*W-1:0]   masked;
   logic [WIN*W-1:0] ext;

   // Mask words past the count, widen to the window, then shift to the offset.
   always_comb begin
      masked = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (CNT_W'(i) < cnt_i) begin
            masked[i*W +: W] = in_i[i*W +: W];
         end
      end
      ext            = '0;
      ext[N*W-1:0]   = masked;
      win_o          = ext << (32'(off_i) * W);
   end

endmodule

// File: rtl/comp_line_packer.sv
// Repacks left-aligned compressed lines into dense full lines, carrying partial
// content between input lines and closing each frame on flush.
module comp_line_packer
   import comp_line_packer_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   comp_line_packer_if.slave   bus
);

   state_e                          state_q, state_d;
   logic [RES_W-1:0]                r_q, r_d;
   logic [(LINE_SIZE-1)*SLOT_W-1:0] res_q, res_d;
   logic                            out_valid_q, out_valid_d;
   logic [LINE_SIZE*SLOT_W-1:0]     out_data_q, out_data_d;
   logic [CNT_W-1:0]                out_cnt_q, out_cnt_d;
   logic                            out_last_q, out_last_d;

   logic                            free;
   logic                            accept;
   logic [CNT_W-1:0]                cnt_sat;
   logic [SUM_W-1:0]                t_sum;
   logic [LINE_SIZE*SLOT_W-1:0]     in_slots;
   logic [WIN_SLOTS*SLOT_W-1:0]     in_win;
   logic [WIN_SLOTS*SLOT_W-1:0]     res_ext;
   logic [WIN_SLOTS*SLOT_W-1:0]     c_win;

   assign free    = !out_valid_q || bus.out_ready;
   assign accept  = bus.in_valid && bus.in_ready;
   assign cnt_sat = sat_cnt(bus.in_cnt);
   assign t_sum   = SUM_W'(r_q) + SUM_W'(cnt_sat);

   assign bus.in_ready  = (state_q == ST_RUN) && free;
   assign bus.out_valid = out_valid_q;
   assign bus.out_cnt   = out_cnt_q;
   assign bus.out_last  = out_last_q;

   // Pair each lifm word with its mt entry so both move through one funnel.
   always_comb begin
      in_slots = '0;
      for (int unsigned i = 0; i < LINE_SIZE; i++) begin
         in_slots[i*SLOT_W +: SLOT_W] = {bus.in_mt[i*MT_W +: MT_W],
                                         bus.in_lifm[i*WORD_WIDTH +: WORD_WIDTH]};
      end
   end

   line_concat #(
      .W     (SLOT_W),
      .N     (LINE_SIZE),
      .WIN   (WIN_SLOTS),
      .CNT_W (CNT_W),
      .OFF_W (RES_W)
   ) u_concat (
      .in_i  (in_slots),
      .cnt_i (cnt_sat),
      .off_i (r_q),
      .win_o (in_win)
   );

   // Residual slots at and above r_q are always zero, so OR-merge is exact.
   always_comb begin
      res_ext = '0;
      res_ext[(LINE_SIZE-1)*SLOT_W-1:0] = res_q;
      c_win = res_ext | in_win;
   end

   // Split the output register back into the lifm and mt buses.
   always_comb begin
      bus.out_lifm = '0;
      bus.out_mt   = '0;
      for (int unsigned i = 0; i < LINE_SIZE; i++) begin
         bus.out_lifm[i*WORD_WIDTH +: WORD_WIDTH] = out_data_q[i*SLOT_W +: WORD_WIDTH];
         bus.out_mt[i*MT_W +: MT_W]               = out_data_q[i*SLOT_W+WORD_WIDTH +: MT_W];
      end
   end

   // Next-state: merge on accept, emit full/final lines, drain tail after overflowing flush.
   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      res_d       = res_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      out_data_d  = out_data_q;
      out_cnt_d   = out_cnt_q;
      out_last_d  = out_last_q;

      unique case (state_q)
         ST_RUN: begin
            if (accept) begin
               if (bus.in_flush && (t_sum <= SUM_W'(LINE_SIZE))) begin
                  out_valid_d = 1'b1;
                  out_data_d  = c_win[LINE_SIZE*SLOT_W-1:0];
                  out_cnt_d   = CNT_W'(t_sum);
                  out_last_d  = 1'b1;
                  r_d         = '0;
                  res_d       = '0;
               end else if (t_sum >= SUM_W'(LINE_SIZE)) begin
                  out_valid_d = 1'b1;
                  out_data_d  = c_win[LINE_SIZE*SLOT_W-1:0];
                  out_cnt_d   = CNT_W'(LINE_SIZE);
                  out_last_d  = 1'b0;
                  r_d         = RES_W'(t_sum - SUM_W'(LINE_SIZE));
                  res_d       = c_win[WIN_SLOTS*SLOT_W-1:LINE_SIZE*SLOT_W];
                  if (bus.in_flush) begin
                     state_d = ST_TAIL;
                  end
               end else begin
                  r_d   = RES_W'(t_sum);
                  res_d = c_win[(LINE_SIZE-1)*SLOT_W-1:0];
               end
            end
         end
         ST_TAIL: begin
            if (free) begin
               out_valid_d = 1'b1;
               out_data_d  = '0;
               out_data_d[(LINE_SIZE-1)*SLOT_W-1:0] = res_q;
               out_cnt_d   = CNT_W'(r_q);
               out_last_d  = 1'b1;
               r_d         = '0;
               res_d       = '0;
               state_d     = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // State, residual and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         r_q         <= '0;
         res_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_cnt_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         res_q       <= res_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_cnt_q   <= out_cnt_d;
         out_last_q  <= out_last_d;
      end
   end

endmodule

// File: tb/tb_comp_line_packer.sv
// Directed bench for comp_line_packer: carry-over, streaming, flush, tail drain,
// backpressure and reset mid-frame.
module tb_comp_line_packer;
   import comp_line_packer_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [SLOT_W-1:0] exp_q[$];

   comp_line_packer_if bus();

   comp_line_packer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [WORD_WIDTH-1:0] lifm_of(input int l, input int i);
      return WORD_WIDTH'(l * 29 + i * 5 + 3);
   endfunction

   function automatic logic [MT_W-1:0] mt_of(input int l, input int i);
      return MT_W'(l * 4099 + i * 131 + 17);
   endfunction

   function automatic logic [SLOT_W-1:0] word_of(input int l, input int i);
      return {mt_of(l, i), lifm_of(l, i)};
   endfunction

   // Valid words from the line pattern, garbage beyond the count.
   task automatic drive_line(input int l, input int cnt, input logic flush);
      int eff;
      eff = (cnt > 32) ? 32 : cnt;
      for (int i = 0; i < 32; i++) begin
         bus.in_lifm[i*WORD_WIDTH +: WORD_WIDTH] = (i < eff) ? lifm_of(l, i) : 8'hA5;
         bus.in_mt[i*MT_W +: MT_W]               = (i < eff) ? mt_of(l, i) : 21'h1ABCDE;
      end
      bus.in_cnt   = CNT_W'(cnt);
      bus.in_flush = flush;
      bus.in_valid = 1'b1;
   endtask

   task automatic push_words(input int l, input int cnt);
      int eff;
      eff = (cnt > 32) ? 32 : cnt;
      for (int i = 0; i < eff; i++) exp_q.push_back(word_of(l, i));
   endtask

   // Called at a negedge; returns at the following negedge with the line accepted.
   task automatic put(input string tag, input int l, input int cnt, input logic flush);
      drive_line(l, cnt, flush);
      #1;
      check_eq({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
      push_words(l, cnt);
      @(negedge clk);
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_flush = 1'b0;
   endtask

   task automatic check_line(input string tag, input int cnt, input logic last);
      logic [SLOT_W-1:0] e;
      logic [SLOT_W-1:0] g;
      check_eq({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
      check_eq({tag, ".cnt"}, 64'(bus.out_cnt), 64'(cnt));
      check_eq({tag, ".last"}, 64'(bus.out_last), 64'(last));
      for (int s = 0; s < 32; s++) begin
         if (s < cnt) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '1;
         end else begin
            e = '0;
         end
         g = {bus.out_mt[s*MT_W +: MT_W], bus.out_lifm[s*WORD_WIDTH +: WORD_WIDTH]};
         check_eq($sformatf("%s.slot%0d", tag, s), 64'(g), 64'(e));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_flush  = 1'b0;
      bus.in_cnt    = '0;
      bus.in_lifm   = '0;
      bus.in_mt     = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("rst.valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst.cnt", 64'(bus.out_cnt), 64'd0);
      check_eq("rst.last", 64'(bus.out_last), 64'd0);
      check_eq("rst.in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);

      // 20 + 20 words: one full line, 8 words carried, closed by empty flush.
      put("t1a", 1, 20, 1'b0);
      check_eq("t1a.no_out", 64'(bus.out_valid), 64'd0);
      put("t1b", 2, 20, 1'b0);
      check_line("t1.line", 32, 1'b0);
      put("t1f", 3, 0, 1'b1);
      check_line("t1.tail8", 8, 1'b1);

      // Full lines back to back, including an over-range count.
      put("t2a", 4, 32, 1'b0);
      check_line("t2.l0", 32, 1'b0);
      put("t2b", 5, 32, 1'b0);
      check_line("t2.l1", 32, 1'b0);
      put("t2c", 6, 63, 1'b0);
      check_line("t2.l2", 32, 1'b0);
      idle();
      @(negedge clk);
      check_eq("t2.drained", 64'(bus.out_valid), 64'd0);

      // R=10 then 5 words with flush: 15-word last line.
      put("t3a", 7, 10, 1'b0);
      check_eq("t3a.no_out", 64'(bus.out_valid), 64'd0);
      put("t3b", 8, 5, 1'b1);
      check_line("t3.line", 15, 1'b1);
      idle();
      @(negedge clk);
      check_eq("t3.drained", 64'(bus.out_valid), 64'd0);

      // R=31 then 32 words with flush: full line, tail cycle, 31-word last line.
      put("t4a", 9, 31, 1'b0);
      check_eq("t4a.no_out", 64'(bus.out_valid), 64'd0);
      put("t4b", 10, 32, 1'b1);
      check_line("t4.full", 32, 1'b0);
      idle();
      #1;
      check_eq("t4.tail_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      check_line("t4.tail", 31, 1'b1);
      check_eq("t4.in_ready_back", 64'(bus.in_ready), 64'd1);
      @(negedge clk);

      // Backpressure: hold a pending line for 5 cycles, then drain and load together.
      bus.out_ready = 1'b0;
      put("t5p", 11, 32, 1'b0);
      check_line("t5.p", 32, 1'b0);
      drive_line(12, 32, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_eq($sformatf("t5.hold%0d.in_ready", k), 64'(bus.in_ready), 64'd0);
         check_eq($sformatf("t5.hold%0d.valid", k), 64'(bus.out_valid), 64'd1);
         check_eq($sformatf("t5.hold%0d.s0", k),
                  64'({bus.out_mt[0 +: MT_W], bus.out_lifm[0 +: WORD_WIDTH]}), 64'(word_of(11, 0)));
         check_eq($sformatf("t5.hold%0d.s31", k),
                  64'({bus.out_mt[31*MT_W +: MT_W], bus.out_lifm[31*WORD_WIDTH +: WORD_WIDTH]}),
                  64'(word_of(11, 31)));
      end
      bus.out_ready = 1'b1;
      #1;
      check_eq("t5.release.in_ready", 64'(bus.in_ready), 64'd1);
      push_words(12, 32);
      @(negedge clk);
      check_line("t5.q", 32, 1'b0);

      // Build R=17 with a pending line, then reset mid-frame.
      put("t6a", 13, 17, 1'b0);
      check_eq("t6a.no_out", 64'(bus.out_valid), 64'd0);
      put("t6b", 14, 32, 1'b0);
      check_line("t6.line", 32, 1'b0);
      idle();
      bus.out_ready = 1'b0;
      @(negedge clk);
      check_eq("t6.pending", 64'(bus.out_valid), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      check_eq("t6.rst.valid", 64'(bus.out_valid), 64'd0);
      check_eq("t6.rst.cnt", 64'(bus.out_cnt), 64'd0);
      reset = 1'b0;
      exp_q.delete();
      bus.out_ready = 1'b1;
      #1;
      check_eq("t6.rst.in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      put("t6f", 15, 0, 1'b1);
      check_line("t6.empty", 0, 1'b1);
      idle();
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
